// File: rtl/node_fold_if.sv
// Start/ready bus shared by all evaluation-tree nodes.
// master drives ST/IN and observes RD/RES/OVF; slave is the node itself.
interface node_fold_if #(
  parameter int WIDTH = 16,
  parameter int NIN   = 4
);
  logic                 ST;
  logic [NIN*WIDTH-1:0] IN;
  logic                 RD;
  logic [WIDTH-1:0]     RES;
  logic                 OVF;

  modport master (output ST, IN, input RD, RES, OVF);
  modport slave  (input ST, IN, output RD, RES, OVF);
endinterface

// File: rtl/node_fold.sv
// Serial fold node: snapshots NIN operands on a start edge and folds one per
// clock under a compile-time mode (select, sum, max, min).
module node_fold #(
  parameter int WIDTH = 16,
  parameter int NIN   = 4,
  parameter int MODE  = 0,
  parameter int SEL   = 0
) (
  input  logic        CLK,
  input  logic        RST,
  node_fold_if.slave  bus,
  output logic        dbg_busy
);
  // Handshake: a start is a 0->1 step of ST seen while RD=1; RD drops on the
  // next edge and returns high exactly NIN edges later with RES/OVF valid.
  // Starts seen while RD=0 are dropped, never queued.
  localparam int IW = $clog2(NIN + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state;
  logic                 st_old;
  logic                 start;
  logic [NIN*WIDTH-1:0] snap;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     op;
  logic [WIDTH-1:0]     acc_nxt;
  logic [WIDTH:0]       sum_w;
  logic [IW-1:0]        idx;
  logic                 carry;
  logic                 carry_nxt;

  assign start    = bus.ST & ~st_old;
  assign dbg_busy = (state == BUSY);

  always_comb begin
    op = '0;
    for (int i = 0; i < NIN; i++) begin
      if (idx == IW'(i)) op = snap[i*WIDTH +: WIDTH];
    end
  end

  // Ties in max/min leave acc alone, so the earliest equal operand wins.
  always_comb begin
    acc_nxt   = acc;
    carry_nxt = carry;
    sum_w     = {1'b0, acc} + {1'b0, op};
    case (MODE)
      1: begin
        acc_nxt   = sum_w[WIDTH-1:0];
        carry_nxt = carry | sum_w[WIDTH];
      end
      2: if (op > acc) acc_nxt = op;
      3: if (op < acc) acc_nxt = op;
      default: if (idx == IW'(SEL)) acc_nxt = op;
    endcase
  end

  always_ff @(posedge CLK) begin
    st_old <= bus.ST;
    if (RST) begin
      state   <= IDLE;
      bus.RD  <= 1'b1;
      bus.RES <= '0;
      bus.OVF <= 1'b0;
      idx     <= '0;
      acc     <= '0;
      carry   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap   <= bus.IN;
            acc    <= bus.IN[WIDTH-1:0];
            idx    <= IW'(1);
            carry  <= 1'b0;
            bus.RD <= 1'b0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (idx == IW'(NIN)) begin
            bus.RES <= acc;
            bus.OVF <= (MODE == 1) ? carry : 1'b0;
            bus.RD  <= 1'b1;
            state   <= IDLE;
          end else begin
            acc   <= acc_nxt;
            carry <= carry_nxt;
            idx   <= idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_node_fold.sv
// Bench for node_fold: four instances (sum, max, min, select SEL=2) share one
// stimulus stream and are checked against an arithmetic reference model.
module tb_node_fold;
  localparam int WIDTH = 16;
  localparam int NIN   = 4;
  localparam int NDUT  = 4;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 st;
  logic [NIN*WIDTH-1:0] in_vec;

  int checks = 0;
  int errors = 0;

  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] last_exp [NDUT];

  logic             rd_a  [NDUT];
  logic [WIDTH-1:0] res_a [NDUT];
  logic             ovf_a [NDUT];
  logic             busy_a[NDUT];

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- DUTs ----------------
  node_fold_if #(.WIDTH(WIDTH), .NIN(NIN)) b_sum ();
  node_fold_if #(.WIDTH(WIDTH), .NIN(NIN)) b_max ();
  node_fold_if #(.WIDTH(WIDTH), .NIN(NIN)) b_min ();
  node_fold_if #(.WIDTH(WIDTH), .NIN(NIN)) b_sel ();

  assign b_sum.ST = st; assign b_sum.IN = in_vec;
  assign b_max.ST = st; assign b_max.IN = in_vec;
  assign b_min.ST = st; assign b_min.IN = in_vec;
  assign b_sel.ST = st; assign b_sel.IN = in_vec;

  assign rd_a[0] = b_sum.RD; assign res_a[0] = b_sum.RES; assign ovf_a[0] = b_sum.OVF;
  assign rd_a[1] = b_max.RD; assign res_a[1] = b_max.RES; assign ovf_a[1] = b_max.OVF;
  assign rd_a[2] = b_min.RD; assign res_a[2] = b_min.RES; assign ovf_a[2] = b_min.OVF;
  assign rd_a[3] = b_sel.RD; assign res_a[3] = b_sel.RES; assign ovf_a[3] = b_sel.OVF;

  node_fold #(.WIDTH(WIDTH), .NIN(NIN), .MODE(1), .SEL(0)) u_sum (
    .CLK(CLK), .RST(RST), .bus(b_sum), .dbg_busy(busy_a[0]));
  node_fold #(.WIDTH(WIDTH), .NIN(NIN), .MODE(2), .SEL(0)) u_max (
    .CLK(CLK), .RST(RST), .bus(b_max), .dbg_busy(busy_a[1]));
  node_fold #(.WIDTH(WIDTH), .NIN(NIN), .MODE(3), .SEL(0)) u_min (
    .CLK(CLK), .RST(RST), .bus(b_min), .dbg_busy(busy_a[2]));
  node_fold #(.WIDTH(WIDTH), .NIN(NIN), .MODE(0), .SEL(2)) u_sel (
    .CLK(CLK), .RST(RST), .bus(b_sel), .dbg_busy(busy_a[3]));

  // ---------------- reference model ----------------
  function automatic int dut_mode(int d);
    return (d == 3) ? 0 : d + 1;
  endfunction

  function automatic int dut_sel(int d);
    return (d == 3) ? 2 : 0;
  endfunction

  // Returns {ovf, res}. A carry happened somewhere iff the exact sum reaches 2^WIDTH.
  function automatic logic [WIDTH:0] model(int mode, int sel, logic [NIN*WIDTH-1:0] v);
    logic [WIDTH-1:0] ops[NIN];
    longint           total;
    logic [WIDTH-1:0] r;
    for (int i = 0; i < NIN; i++) ops[i] = v[i*WIDTH +: WIDTH];
    case (mode)
      1: begin
        total = 0;
        for (int i = 0; i < NIN; i++) total += longint'(ops[i]);
        return {(total >= (longint'(1) << WIDTH)), total[WIDTH-1:0]};
      end
      2: begin
        r = ops[0];
        for (int i = 1; i < NIN; i++) if (ops[i] > r) r = ops[i];
        return {1'b0, r};
      end
      3: begin
        r = ops[0];
        for (int i = 1; i < NIN; i++) if (ops[i] < r) r = ops[i];
        return {1'b0, r};
      end
      default: return {1'b0, ops[sel]};
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic rd_exp, input bit use_last);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s_rd_d%0d", tag, d), 32'(rd_a[d]), 32'(rd_exp));
      check($sformatf("%s_res_d%0d", tag, d), 32'(res_a[d]),
            use_last ? 32'(last_exp[d][WIDTH-1:0]) : 32'd0);
      check($sformatf("%s_ovf_d%0d", tag, d), 32'(ovf_a[d]),
            use_last ? 32'(last_exp[d][WIDTH]) : 32'd0);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_in();
    for (int i = 0; i < NIN; i++) in_vec[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  // Raises ST in the current (idle) cycle, scrambles IN after the start edge,
  // optionally pulses ST again mid-fold, and checks RD low for exactly NIN cycles.
  task automatic run_fold(input logic [NIN*WIDTH-1:0] v, input bit extra_pulse);
    logic [WIDTH:0] e;
    in_vec = v;
    st     = 1'b1;
    for (int d = 0; d < NDUT; d++) exp_q.push_back(model(dut_mode(d), dut_sel(d), v));
    for (int c = 0; c < NIN; c++) begin
      tick();
      check_all($sformatf("busy_c%0d", c), 1'b0, 1'b1);
      if (c == 0) begin
        st = 1'b0;
        rand_in();
      end
      if (extra_pulse && c == 1) st = 1'b1;
      if (extra_pulse && c == 2) st = 1'b0;
    end
    tick();
    for (int d = 0; d < NDUT; d++) begin
      e = exp_q.pop_front();
      check($sformatf("done_rd_d%0d", d), 32'(rd_a[d]), 32'd1);
      check($sformatf("done_res_d%0d", d), 32'(res_a[d]), 32'(e[WIDTH-1:0]));
      check($sformatf("done_ovf_d%0d", d), 32'(ovf_a[d]), 32'(e[WIDTH]));
      last_exp[d] = e;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [NIN*WIDTH-1:0] v;
    for (int d = 0; d < NDUT; d++) last_exp[d] = '0;
    RST = 1'b1;
    st  = 1'b1;
    rand_in();
    tick();
    tick();
    check_all("reset", 1'b1, 1'b0);
    RST = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_all($sformatf("st_hold_c%0d", c), 1'b1, 1'b0);
    end
    st = 1'b0;
    tick();

    // Sum wrap, then small sum with a mid-fold ST pulse; back-to-back from here on.
    run_fold({16'h0001, 16'h0010, 16'h0002, 16'hFFFF}, 1'b0);
    run_fold({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b1);
    // Max/min unsigned compare with a tie at 0x8000.
    run_fold({16'h8000, 16'h7FFF, 16'h8000, 16'h0005}, 1'b0);
    // Select SEL=2.
    run_fold({16'h000D, 16'h000C, 16'h000B, 16'h000A}, 1'b0);
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NIN; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      run_fold(v, bit'($urandom_range(0, 1)));
    end

    // Mid-fold reset aborts with RES forced to 0.
    rand_in();
    st = 1'b1;
    tick();
    st = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int d = 0; d < NDUT; d++) last_exp[d] = '0;
    check_all("midreset", 1'b1, 1'b1);
    tick();
    check_all("post_reset_idle", 1'b1, 1'b1);
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < NIN; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      run_fold(v, 1'b0);
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
